// File: rtl/game_event_logger_if.sv
// Record stream from game_event_logger to its consumer: show-ahead head record
// with a valid/ready pop handshake.
interface game_event_logger_if #(
  parameter int unsigned TS_WIDTH = 8
) ();
  logic                  evt_valid;
  logic                  evt_ready;
  logic [TS_WIDTH+3:0]   evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/game_event_logger.sv
// Turns counter LOSER/WINNER/GAMEOVER pulses into {type, who, ts} records in a
// show-ahead FIFO. Define GAME_EVT_TIMESTAMP_EN to fill the ts field with a cycle count.
module game_event_logger #(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned TS_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  loser,
  input  logic                  winner,
  input  logic                  gameover,
  input  logic [1:0]            who,
  input  logic                  flush,
  game_event_logger_if.master   evt,
  output logic [ADDR_W:0]       fifo_count,
  output logic [7:0]            drop_cnt,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned REC_W = TS_WIDTH + 4;

  typedef enum logic [1:0] {
    EV_NONE     = 2'b00,
    EV_LOSER    = 2'b01,
    EV_WINNER   = 2'b10,
    EV_GAMEOVER = 2'b11
  } ev_type_e;

  logic [REC_W-1:0]    r_mem [DEPTH];
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic [7:0]          r_drop_cnt;
  logic                r_overflow;
  logic                r_pend_valid;
  logic [REC_W-1:0]    r_pend_rec;

  logic [TS_WIDTH-1:0] w_ts;
  logic                w_pop;
  logic                w_full;
  logic                w_cand_valid;
  logic [REC_W-1:0]    w_cand_rec;
  logic [REC_W-1:0]    w_go_rec;
  logic                w_nxt_pend_valid;
  logic [REC_W-1:0]    w_nxt_pend_rec;
  logic [1:0]          w_rule_drops;
  logic                w_push;
  logic [1:0]          w_drops;
  logic [8:0]          w_drop_sum;
  logic [7:0]          w_drop_nxt;

`ifdef GAME_EVT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_WIDTH'(1);
    end
  end

  assign w_ts = r_ts;
`else
  assign w_ts = '0;
`endif

  function automatic logic [REC_W-1:0] mk_rec(ev_type_e t, logic [1:0] w,
                                             logic [TS_WIDTH-1:0] ts);
    return {t, w, ts};
  endfunction

  always_comb begin
    w_pop            = (r_count != '0) && evt.evt_ready;
    w_full           = (r_count == (ADDR_W+1)'(DEPTH));
    w_go_rec         = mk_rec(EV_GAMEOVER, who, w_ts);
    w_cand_valid     = 1'b0;
    w_cand_rec       = '0;
    w_nxt_pend_valid = 1'b0;
    w_nxt_pend_rec   = r_pend_rec;
    w_rule_drops     = '0;
    // The single write slot goes to pending, then LOSER, then WINNER, then GAMEOVER.
    // A GAMEOVER that loses the slot is deferred one cycle rather than dropped.
    if (r_pend_valid) begin
      w_cand_valid     = 1'b1;
      w_cand_rec       = r_pend_rec;
      w_rule_drops     = {1'b0, loser} + {1'b0, winner};
      w_nxt_pend_valid = gameover;
      w_nxt_pend_rec   = w_go_rec;
    end else if (loser || winner) begin
      w_cand_valid     = 1'b1;
      w_cand_rec       = loser ? mk_rec(EV_LOSER, 2'b00, w_ts)
                               : mk_rec(EV_WINNER, 2'b00, w_ts);
      w_rule_drops     = {1'b0, loser && winner};
      w_nxt_pend_valid = gameover;
      w_nxt_pend_rec   = w_go_rec;
    end else if (gameover) begin
      w_cand_valid     = 1'b1;
      w_cand_rec       = w_go_rec;
    end
    w_push     = w_cand_valid && (!w_full || w_pop);
    w_drops    = w_rule_drops + {1'b0, w_cand_valid && !w_push};
    w_drop_sum = {1'b0, r_drop_cnt} + 9'(w_drops);
    w_drop_nxt = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_drop_cnt   <= '0;
      r_overflow   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_rec   <= '0;
    end else if (flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_drop_cnt   <= '0;
      r_overflow   <= 1'b0;
      r_pend_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      r_pend_valid <= w_nxt_pend_valid;
      r_pend_rec   <= w_nxt_pend_rec;
      r_drop_cnt   <= w_drop_nxt;
      if (w_drops != '0) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_l && !flush && w_push) begin
      r_mem[r_wr_ptr] <= w_cand_rec;
    end
  end

  // Storage is not reset; the head is masked so an empty FIFO always reads zero.
  assign evt.evt_valid = (r_count != '0);
  assign evt.evt_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign fifo_count    = r_count;
  assign drop_cnt      = r_drop_cnt;
  assign overflow      = r_overflow;

endmodule
